// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// The transmitter has no busy flag, so the frame is timed here from the latched divisor.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int RST_HOLDOFF = 0,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           cfg_bps,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [2:0]           tx_bps
);

  localparam int              IW1       = ID_W + 1;
  localparam logic [ID_W:0]   NR        = IW1'(N_REQ);
  localparam logic [15:0]     HOLD_LAST = 16'(RST_HOLDOFF - 1);
  localparam logic [15:0]     GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_HOLD, S_IDLE, S_START, S_FRAME, S_GAP} state_t;

  state_t                  state, state_nxt;
  logic [N_REQ-1:0][7:0]   req_bytes;
  logic [12:0]             div, per_cnt;
  logic [3:0]              bit_cnt;
  logic [15:0]             gap_cnt, hold_cnt;
  logic [2:0]              bps_c;
  logic                    win_vld;
  logic [ID_W-1:0]         win_id;
  logic [ID_W:0]           sum;
  logic                    per_wrap;

  assign req_bytes = req_data;
  assign bps_c     = (cfg_bps > 3'd4) ? 3'd0 : cfg_bps;
  assign per_wrap  = (per_cnt == div);
  assign busy      = (state != S_IDLE);
  assign tx_start  = (state == S_START);

  function automatic logic [12:0] div_of(input logic [2:0] c);
    case (c)
      3'd1:    return 13'd2603;
      3'd2:    return 13'd1301;
      3'd3:    return 13'd867;
      3'd4:    return 13'd433;
      default: return 13'd5208;
    endcase
  endfunction

  // Search starts one past the last winner and wraps modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = cur_id;
    sum     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sum = {1'b0, cur_id} + IW1'(i);
      if (sum >= NR) sum = sum - NR;
      if (!win_vld && req[sum[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == S_START) gnt[cur_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (RST_HOLDOFF > 0) ? S_HOLD : S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD:  if (hold_cnt == HOLD_LAST) state_nxt = S_IDLE;
      S_IDLE:  if (win_vld) state_nxt = S_START;
      S_START: state_nxt = S_FRAME;
      S_FRAME: if (per_wrap && bit_cnt == 4'd9) state_nxt = S_GAP;
      S_GAP:   if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_id   <= ID_W'(N_REQ - 1);
      tx_data  <= '0;
      tx_bps   <= '0;
      div      <= 13'd5208;
      per_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_HOLD: hold_cnt <= hold_cnt + 16'd1;
        S_IDLE: if (win_vld) begin
          cur_id  <= win_id;
          tx_data <= req_bytes[win_id];
          tx_bps  <= bps_c;
          div     <= div_of(bps_c);
        end
        S_START: begin
          per_cnt <= '0;
          bit_cnt <= '0;
        end
        S_FRAME: begin
          gap_cnt <= '0;
          if (per_wrap) begin
            per_cnt <= '0;
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            per_cnt <= per_cnt + 13'd1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: arbitration vectors from reset, then
// multi-cycle sequences for frame timing, round-robin, held values and resets.
module tb_uart_tx_arbiter;

  logic        clk, rst_n, rst_n_h;
  logic [2:0]  cfg_bps;
  logic [3:0]  req, req_h;
  logic [31:0] req_data;
  logic [3:0]  gnt, gnt_h;
  logic        busy, busy_h, tx_start, tx_start_h;
  logic [1:0]  cur_id, cur_id_h;
  logic [7:0]  tx_data, tx_data_h;
  logic [2:0]  tx_bps, tx_bps_h;

  int errors, checks;

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .RST_HOLDOFF(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bps(cfg_bps), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .cur_id(cur_id), .tx_start(tx_start),
    .tx_data(tx_data), .tx_bps(tx_bps));

  uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .RST_HOLDOFF(100)) dut_h (
    .clk(clk), .rst_n(rst_n_h), .cfg_bps(cfg_bps), .req(req_h), .req_data(req_data),
    .gnt(gnt_h), .busy(busy_h), .cur_id(cur_id_h), .tx_start(tx_start_h),
    .tx_data(tx_data_h), .tx_bps(tx_bps_h));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] bps;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic [7:0] data;
    logic [2:0] tbps;
    logic       start;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < limit);
    if (!tx_start) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: no tx_start within %0d cycles", limit);
    end
  endtask

  // Called on the START cycle; returns the number of consecutive busy cycles.
  task automatic measure_busy(input int limit, output int n);
    n = 1;
    while (n < limit) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic stable;
    errors = 0;
    checks = 0;
    rst_n = 1'b0; rst_n_h = 1'b0;
    req = '0; req_h = '0; cfg_bps = 3'd0; req_data = '0;
    repeat (3) @(negedge clk);

    check("rst_gnt", gnt, 4'b0000);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_bps", tx_bps, 3'd0);
    check("rst_cur_id", cur_id, 2'd3);
    check("rst_busy", busy, 1'b0);
    check("rst_busy_holdoff", busy_h, 1'b1);

    // Holdoff instance: 100 HOLD cycles, one IDLE arbitration, then START.
    cfg_bps = 3'd4; req_data = 32'hE1965A3C; req_h = 4'b0001;
    rst_n_h = 1'b1;
    n = 0;
    while (!tx_start_h && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 50) check("hold_busy_mid", busy_h, 1'b1);
      if (n == 99) check("hold_no_start_99", tx_start_h, 1'b0);
    end
    check("hold_start_window", (n >= 100 && n <= 102), 1'b1);
    check("hold_gnt", gnt_h, 4'b0001);
    check("hold_cur_id", cur_id_h, 2'd0);
    check("hold_tx_data", tx_data_h, 8'h3C);
    check("hold_tx_bps", tx_bps_h, 3'd4);
    req_h = '0; rst_n_h = 1'b0;

    // Arbitration from reset (cur_id = 3, so search starts at 0); frames aborted by reset.
    vt[0] = '{3'd4, 4'b0001, 4'b0001, 2'd0, 8'h3C, 3'd4, 1'b1};
    vt[1] = '{3'd1, 4'b0100, 4'b0100, 2'd2, 8'h96, 3'd1, 1'b1};
    vt[2] = '{3'd2, 4'b1010, 4'b0010, 2'd1, 8'h5A, 3'd2, 1'b1};
    vt[3] = '{3'd3, 4'b1000, 4'b1000, 2'd3, 8'hE1, 3'd3, 1'b1};
    vt[4] = '{3'd5, 4'b1100, 4'b0100, 2'd2, 8'h96, 3'd0, 1'b1};
    vt[5] = '{3'd7, 4'b1111, 4'b0001, 2'd0, 8'h3C, 3'd0, 1'b1};
    vt[6] = '{3'd0, 4'b0000, 4'b0000, 2'd3, 8'h00, 3'd0, 1'b0};
    req_data = 32'hE1965A3C;
    foreach (vt[i]) begin
      cfg_bps = vt[i].bps;
      req = vt[i].req;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_tx_start", i), tx_start, vt[i].start);
      check($sformatf("v%0d_gnt", i), gnt, vt[i].gnt);
      check($sformatf("v%0d_cur_id", i), cur_id, vt[i].id);
      check($sformatf("v%0d_tx_data", i), tx_data, vt[i].data);
      check($sformatf("v%0d_tx_bps", i), tx_bps, vt[i].tbps);
      check($sformatf("v%0d_busy", i), busy, vt[i].start);
      req = '0;
      @(negedge clk);
      check($sformatf("v%0d_start_1cyc", i), tx_start, 1'b0);
      check($sformatf("v%0d_gnt_1cyc", i), gnt, 4'b0000);
      check($sformatf("v%0d_busy_frame", i), busy, vt[i].start);
    end

    // Single frame at 115200: busy spans START + 4340 FRAME + 2 GAP cycles.
    cfg_bps = 3'd4; req_data = 32'h000000A5; req = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(4, n);
    check("a_latency", n, 1);
    check("a_gnt", gnt, 4'b0001);
    check("a_tx_data", tx_data, 8'hA5);
    check("a_tx_bps", tx_bps, 3'd4);
    req = '0;
    measure_busy(60000, n);
    check("a_busy_len", n, 4343);
    check("a_idle_after", busy, 1'b0);

    // All four held: grants 0,1,2,3,0 spaced 4344 cycles.
    cfg_bps = 3'd4; req_data = 32'h13121110; req = 4'b1111;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_start(5000, n);
      check($sformatf("rr%0d_spacing", k), n, (k == 0) ? 1 : 4344);
      check($sformatf("rr%0d_gnt", k), gnt, 4'b0001 << (k % 4));
      check($sformatf("rr%0d_onehot", k), $countones(gnt), 1);
      check($sformatf("rr%0d_tx_data", k), tx_data, 8'h10 + 8'(k % 4));
    end
    req = '0;

    // Mid-frame config/data change must not disturb the frame in flight.
    n = 1;
    stable = 1'b1;
    while (busy && n < 60000) begin
      @(negedge clk);
      if (busy) n++;
      if (n == 2000) begin
        cfg_bps = 3'd0;
        req_data = 32'hFFFFFFFF;
      end
      if (tx_data !== 8'h10 || tx_bps !== 3'd4) stable = 1'b0;
    end
    check("mid_busy_len", n, 4343);
    check("mid_held_stable", stable, 1'b1);
    check("mid_tx_data_after", tx_data, 8'h10);
    check("mid_tx_bps_after", tx_bps, 3'd4);

    // Reset asserted mid-frame, then pending request regranted after release.
    cfg_bps = 3'd4; req_data = 32'hE1965A3C; req = 4'b0100;
    wait_start(10, n);
    check("r_gnt_before", gnt, 4'b0100);
    check("r_cur_id_before", cur_id, 2'd2);
    repeat (1000) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("r_async_gnt", gnt, 4'b0000);
    check("r_async_tx_start", tx_start, 1'b0);
    check("r_async_tx_data", tx_data, 8'h00);
    check("r_async_tx_bps", tx_bps, 3'd0);
    check("r_async_cur_id", cur_id, 2'd3);
    check("r_async_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(4, n);
    check("r_regrant_window", (n >= 1 && n <= 2), 1'b1);
    check("r_regrant_gnt", gnt, 4'b0100);
    check("r_regrant_data", tx_data, 8'h96);
    req = '0;

    // Out-of-range baud code clamps to 9600: frame of 10*5209 cycles.
    cfg_bps = 3'd6; req_data = 32'h00000077; req = 4'b0001;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(4, n);
    check("c_gnt", gnt, 4'b0001);
    check("c_tx_bps", tx_bps, 3'd0);
    check("c_tx_data", tx_data, 8'h77);
    req = '0;
    measure_busy(60000, n);
    check("c_busy_len", n, 52093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
